xbus_slave_buf: RTL and testbench

//  Registered request/response buffer between one ariele_xbar slave port (sN_*) and one bus slave (gpio, tile HPI).

---
 rtl/xbus_slave_buf.sv | 160 ++++++++++++++++
 tb/tb_xbus_slave_buf.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/xbus_slave_buf.sv
// xbus_slave_buf: registered request/response buffer between one xbar slave
// port and one bus slave. It breaks the timing paths in both directions. The
// request slot faces the slave, and the response register faces the xbar. The
// number of outstanding reads is capped at DEPTH.
//
// Optional feature macro: XBUS_BUF_TIMEOUT_EN. When it is defined, the oldest
// outstanding read is answered with ERR_DATA after TIMEOUT cycles. The slave's
// late response to that read is then swallowed.
//
// Ports:
//   clk_i, rst_i                  clock; synchronous reset, active-low
//   host_req_i/we_i/addr_bi/be_i/wdata_bi   request from the xbar
//   host_ack_o                    request accepted this cycle
//   host_resp_o, host_rdata_bo    registered read response (1-cycle pulse)
//   dev_req_o/we_o/addr_bo/be_o/wdata_bo    captured request toward the slave
//   dev_ack_i                     slave accepted the request
//   dev_resp_i, dev_rdata_bi      slave read response
module xbus_slave_buf #(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned TIMEOUT  = 1024,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        host_req_i,
    input  logic        host_we_i,
    input  logic [31:0] host_addr_bi,
    input  logic [3:0]  host_be_i,
    input  logic [31:0] host_wdata_bi,
    output logic        host_ack_o,
    output logic        host_resp_o,
    output logic [31:0] host_rdata_bo,
    output logic        dev_req_o,
    output logic        dev_we_o,
    output logic [31:0] dev_addr_bo,
    output logic [3:0]  dev_be_o,
    output logic [31:0] dev_wdata_bo,
    input  logic        dev_ack_i,
    input  logic        dev_resp_i,
    input  logic [31:0] dev_rdata_bi
);
    localparam int unsigned   CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {EMPTY, PEND} slot_e;

    slot_e          slot_q, slot_d;
    logic           we_q;
    logic [31:0]    addr_q, wdata_q;
    logic [3:0]     be_q;
    logic [CW-1:0]  rd_out_q, rd_out_d;
    logic           resp_q, resp_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           accept, rd_inc;
    logic [7:0]     drop;       // dead reads whose slave response must be swallowed
    logic           swallow, tmo_fire;

    // Ack is gated by reset so that nothing is accepted while rst_i is low.
    assign host_ack_o = rst_i & (slot_q == EMPTY) & (host_we_i | (rd_out_q < DEPTH_C));
    assign accept     = host_req_i & host_ack_o;
    assign rd_inc     = accept & ~host_we_i;

`ifdef XBUS_BUF_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [7:0]    drop_q, drop_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          only_read, tmo_run;

    // A read still in the slot has not reached the slave yet. Its wait does
    // not start until the slave takes it.
    assign only_read = (slot_q == PEND) & ~we_q & (rd_out_q == CW'(1));
    assign tmo_run   = (8'(rd_out_q) > drop_q) & ~only_read & ~dev_resp_i;
    assign tmo_fire  = tmo_run & (tmo_q == TW'(TIMEOUT - 1));
    assign swallow   = dev_resp_i & (drop_q != 8'd0);
    assign drop      = drop_q;

    always_comb begin
        tmo_d  = tmo_q;
        drop_d = drop_q;
        if (dev_resp_i || rd_out_q == '0 || tmo_fire)
            tmo_d = '0;
        else if (tmo_run)
            tmo_d = tmo_q + TW'(1);
        if (tmo_fire)
            drop_d = drop_q + 8'd1;
        else if (swallow)
            drop_d = drop_q - 8'd1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            tmo_q  <= '0;
            drop_q <= '0;
        end else begin
            tmo_q  <= tmo_d;
            drop_q <= drop_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign drop           = 8'd0;
    assign swallow        = 1'b0;
    assign tmo_fire       = 1'b0;
`endif

    always_comb begin
        slot_d = slot_q;
        case (slot_q)
            EMPTY:   if (accept)    slot_d = PEND;
            PEND:    if (dev_ack_i) slot_d = EMPTY;
            default: slot_d = EMPTY;
        endcase
    end

    // A response with no read outstanding is a stray and is dropped.
    always_comb begin
        resp_d   = (dev_resp_i & (rd_out_q != '0) & (drop == 8'd0) & ~swallow) | tmo_fire;
        rd_out_d = rd_out_q + CW'(rd_inc) - CW'(resp_d);
        rdata_d  = rdata_q;
        if (tmo_fire)
            rdata_d = ERR_DATA;
        else if (resp_d)
            rdata_d = dev_rdata_bi;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            slot_q   <= EMPTY;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            rd_out_q <= '0;
            resp_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            slot_q   <= slot_d;
            rd_out_q <= rd_out_d;
            resp_q   <= resp_d;
            rdata_q  <= rdata_d;
            if (accept) begin
                we_q    <= host_we_i;
                addr_q  <= host_addr_bi;
                be_q    <= host_be_i;
                wdata_q <= host_wdata_bi;
            end
        end
    end

    assign dev_req_o     = (slot_q == PEND);
    assign dev_we_o      = we_q;
    assign dev_addr_bo   = addr_q;
    assign dev_be_o      = be_q;
    assign dev_wdata_bo  = wdata_q;
    assign host_resp_o   = resp_q;
    assign host_rdata_bo = rdata_q;

endmodule

// File: tb/tb_xbus_slave_buf.sv
module tb_xbus_slave_buf;
    logic        clk = 1'b0;
    logic        rst, req, we, dack, dresp;
    logic [31:0] addr, wdata, drdata;
    logic [3:0]  be;
    logic        ack, resp, dreq, dwe;
    logic [31:0] rdata, daddr, dwdata;
    logic [3:0]  dbe;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    xbus_slave_buf #(.DEPTH(2), .TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk_i(clk), .rst_i(rst),
        .host_req_i(req), .host_we_i(we), .host_addr_bi(addr), .host_be_i(be),
        .host_wdata_bi(wdata), .host_ack_o(ack), .host_resp_o(resp), .host_rdata_bo(rdata),
        .dev_req_o(dreq), .dev_we_o(dwe), .dev_addr_bo(daddr), .dev_be_o(dbe),
        .dev_wdata_bo(dwdata), .dev_ack_i(dack), .dev_resp_i(dresp), .dev_rdata_bi(drdata)
    );

    typedef struct {
        logic        rst, req, we;
        logic [31:0] addr, wdata;
        logic        dack, dresp;
        logic [31:0] drdata;
        logic        e_ack, e_dreq, e_dwe;
        logic [31:0] e_daddr, e_dwdata;
        logic        e_resp;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t tv[30];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic q, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic da, input logic dr, input logic [31:0] rd);
        rst = r; req = q; we = w; addr = a; wdata = wd; dack = da; dresp = dr; drdata = rd;
    endtask

    task automatic idle();
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        be = 4'hF;
        //          rst req we addr          wdata         dack dresp drdata         ack dreq dwe daddr        dwdata        resp rdata
        tv[0]  = '{0, 1, 0, 32'h0,         32'h0,        0, 0, 32'h0,         0, 0, 0, 32'h0,        32'h0,        0, 32'h0};
        tv[1]  = '{0, 1, 0, 32'h0,         32'h0,        0, 0, 32'h0,         0, 0, 0, 32'h0,        32'h0,        0, 32'h0};
        tv[2]  = '{1, 1, 1, 32'h8000_0000, 32'h1234_5678, 1, 0, 32'h0,        1, 1, 1, 32'h8000_0000, 32'h1234_5678, 0, 32'h0};
        tv[3]  = '{1, 1, 1, 32'h1,         32'h0,        1, 0, 32'h0,         0, 0, 1, 32'h8000_0000, 32'h1234_5678, 0, 32'h0};
        tv[4]  = '{1, 1, 0, 32'h10,        32'h0,        1, 0, 32'h0,         1, 1, 0, 32'h10,       32'h0,        0, 32'h0};
        tv[5]  = '{1, 0, 0, 32'h0,         32'h0,        1, 0, 32'h0,         0, 0, 0, 32'h10,       32'h0,        0, 32'h0};
        tv[6]  = '{1, 0, 0, 32'h0,         32'h0,        0, 0, 32'h0,         1, 0, 0, 32'h10,       32'h0,        0, 32'h0};
        tv[7]  = '{1, 0, 0, 32'h0,         32'h0,        0, 0, 32'h0,         1, 0, 0, 32'h10,       32'h0,        0, 32'h0};
        tv[8]  = '{1, 0, 0, 32'h0,         32'h0,        0, 1, 32'hCAFE_F00D, 1, 0, 0, 32'h10,       32'h0,        1, 32'hCAFE_F00D};
        tv[9]  = '{1, 0, 0, 32'h0,         32'h0,        0, 0, 32'h1111_1111, 1, 0, 0, 32'h10,       32'h0,        0, 32'hCAFE_F00D};
        tv[10] = '{1, 0, 0, 32'h0,         32'h0,        0, 1, 32'h2222_2222, 1, 0, 0, 32'h10,       32'h0,        0, 32'hCAFE_F00D};
        tv[11] = '{1, 1, 0, 32'h20,        32'h0,        0, 0, 32'h0,         1, 1, 0, 32'h20,       32'h0,        0, 32'hCAFE_F00D};
        tv[12] = '{1, 1, 0, 32'h24,        32'h0,        1, 0, 32'h0,         0, 0, 0, 32'h20,       32'h0,        0, 32'hCAFE_F00D};
        tv[13] = '{1, 1, 0, 32'h24,        32'h0,        0, 0, 32'h0,         1, 1, 0, 32'h24,       32'h0,        0, 32'hCAFE_F00D};
        tv[14] = '{1, 1, 0, 32'h28,        32'h0,        1, 0, 32'h0,         0, 0, 0, 32'h24,       32'h0,        0, 32'hCAFE_F00D};
        tv[15] = '{1, 1, 0, 32'h28,        32'h0,        0, 0, 32'h0,         0, 0, 0, 32'h24,       32'h0,        0, 32'hCAFE_F00D};
        tv[16] = '{1, 1, 1, 32'h30,        32'h9999_0000, 0, 0, 32'h0,        1, 1, 1, 32'h30,       32'h9999_0000, 0, 32'hCAFE_F00D};
        tv[17] = '{1, 1, 0, 32'h28,        32'h0,        1, 0, 32'h0,         0, 0, 1, 32'h30,       32'h9999_0000, 0, 32'hCAFE_F00D};
        tv[18] = '{1, 1, 0, 32'h28,        32'h0,        0, 1, 32'hAAAA_0001, 0, 0, 1, 32'h30,       32'h9999_0000, 1, 32'hAAAA_0001};
        tv[19] = '{1, 1, 0, 32'h28,        32'h0,        1, 0, 32'h0,         1, 1, 0, 32'h28,       32'h0,        0, 32'hAAAA_0001};
        tv[20] = '{1, 0, 0, 32'h0,         32'h0,        1, 0, 32'h0,         0, 0, 0, 32'h28,       32'h0,        0, 32'hAAAA_0001};
        tv[21] = '{1, 0, 0, 32'h0,         32'h0,        0, 1, 32'hBBBB_0002, 0, 0, 0, 32'h28,       32'h0,        1, 32'hBBBB_0002};
        tv[22] = '{1, 0, 0, 32'h0,         32'h0,        0, 1, 32'hCCCC_0003, 1, 0, 0, 32'h28,       32'h0,        1, 32'hCCCC_0003};
        tv[23] = '{1, 0, 0, 32'h0,         32'h0,        0, 0, 32'h0,         1, 0, 0, 32'h28,       32'h0,        0, 32'hCCCC_0003};
        tv[24] = '{1, 1, 0, 32'h40,        32'h0,        0, 0, 32'h0,         1, 1, 0, 32'h40,       32'h0,        0, 32'hCCCC_0003};
        tv[25] = '{1, 0, 0, 32'h0,         32'h0,        1, 0, 32'h0,         0, 0, 0, 32'h40,       32'h0,        0, 32'hCCCC_0003};
        tv[26] = '{1, 1, 0, 32'h44,        32'h0,        0, 1, 32'hDDDD_0004, 1, 1, 0, 32'h44,       32'h0,        1, 32'hDDDD_0004};
        tv[27] = '{1, 0, 0, 32'h0,         32'h0,        1, 0, 32'h0,         0, 0, 0, 32'h44,       32'h0,        0, 32'hDDDD_0004};
        tv[28] = '{1, 0, 0, 32'h0,         32'h0,        0, 1, 32'hEEEE_0005, 1, 0, 0, 32'h44,       32'h0,        1, 32'hEEEE_0005};
        tv[29] = '{1, 0, 0, 32'h0,         32'h0,        0, 1, 32'hFFFF_FFFF, 1, 0, 0, 32'h44,       32'h0,        0, 32'hEEEE_0005};

        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            drive(tv[i].rst, tv[i].req, tv[i].we, tv[i].addr, tv[i].wdata,
                  tv[i].dack, tv[i].dresp, tv[i].drdata);
            #1;
            chk($sformatf("v%0d.ack", i), {31'b0, ack}, {31'b0, tv[i].e_ack});
            @(posedge clk); #1;
            chk($sformatf("v%0d.dev_req", i), {31'b0, dreq}, {31'b0, tv[i].e_dreq});
            chk($sformatf("v%0d.dev_we", i), {31'b0, dwe}, {31'b0, tv[i].e_dwe});
            chk($sformatf("v%0d.dev_addr", i), daddr, tv[i].e_daddr);
            chk($sformatf("v%0d.dev_wdata", i), dwdata, tv[i].e_dwdata);
            chk($sformatf("v%0d.resp", i), {31'b0, resp}, {31'b0, tv[i].e_resp});
            chk($sformatf("v%0d.rdata", i), rdata, tv[i].e_rdata);
        end

        // Stall: the slave holds off its ack. The captured fields must stay
        // put while the host inputs change and a stray response arrives.
        @(negedge clk);
        drive(1, 1, 1, 32'h5000, 32'h55AA_55AA, 0, 0, 0);
        be = 4'h3;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(1, 1, 0, 32'hBAD0_0000 + k, 32'h0, 0, 1, 32'h1357_9BDF);
            be = 4'hC;
            #1;
            chk($sformatf("stall%0d.ack", k), {31'b0, ack}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("stall%0d.dev_req", k), {31'b0, dreq}, 32'd1);
            chk($sformatf("stall%0d.dev_addr", k), daddr, 32'h5000);
            chk($sformatf("stall%0d.dev_be", k), {28'b0, dbe}, 32'h3);
            chk($sformatf("stall%0d.dev_wdata", k), dwdata, 32'h55AA_55AA);
            chk($sformatf("stall%0d.stray_resp", k), {31'b0, resp}, 32'd0);
        end
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1, 0, 0);
        be = 4'hF;
        @(posedge clk); #1;
        chk("stall.release", {31'b0, dreq}, 32'd0);

        // A reset in mid-transfer drops the outstanding read, so the slave's
        // later response to it is ignored.
        @(negedge clk);
        drive(1, 1, 0, 32'h60, 0, 1, 0, 0);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        drive(0, 1, 0, 32'h64, 0, 0, 0, 0);
        #1;
        chk("rst.ack", {31'b0, ack}, 32'd0);
        @(posedge clk); #1;
        chk("rst.dev_req", {31'b0, dreq}, 32'd0);
        chk("rst.rdata", rdata, 32'd0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 1, 32'h7777_7777);
        @(posedge clk); #1;
        chk("rst.late_resp", {31'b0, resp}, 32'd0);

`ifdef XBUS_BUF_TIMEOUT_EN
        begin
            int n;
            @(negedge clk);
            drive(1, 1, 0, 32'h70, 0, 1, 0, 0);
            @(posedge clk); #1;
            @(negedge clk);
            drive(1, 0, 0, 0, 0, 1, 0, 0);
            @(posedge clk); #1;
            n = 41;
            for (int c = 1; c <= 40; c++) begin
                idle();
                if (resp) begin
                    n = c;
                    break;
                end
            end
            chk("tmo.latency", n, 32'd16);
            chk("tmo.rdata", rdata, 32'hDEADBEEF);
            @(negedge clk);
            drive(1, 0, 0, 0, 0, 0, 1, 32'h0BAD_0BAD);
            @(posedge clk); #1;
            chk("tmo.swallow", {31'b0, resp}, 32'd0);
            idle();
            chk("tmo.rdata_hold", rdata, 32'hDEADBEEF);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
